// File: rtl/alu_share_if.sv
// Request/response bundle between the two ALU requesters and alu_share_arbiter.
// master = requester side, slave = arbiter side.
interface alu_share_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_aluA;
  logic [63:0] req0_aluB;
  logic [3:0]  req0_alufun;
  logic        req0_set_cc;
  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_aluA;
  logic [63:0] req1_aluB;
  logic [3:0]  req1_alufun;
  logic        req1_set_cc;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [63:0] rsp_valE;
  logic [2:0]  cc;
  logic [3:0]  cond_ifun;
  logic        Cnd;

  modport master (
    output req0_valid, req0_aluA, req0_aluB,
    output req0_alufun, req0_set_cc,
    output req1_valid, req1_aluA, req1_aluB,
    output req1_alufun, req1_set_cc,
    output rsp0_ready, rsp1_ready, cond_ifun,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid,
    input  rsp_valE, cc, Cnd
  );

  modport slave (
    input  req0_valid, req0_aluA, req0_aluB,
    input  req0_alufun, req0_set_cc,
    input  req1_valid, req1_aluA, req1_aluB,
    input  req1_alufun, req1_set_cc,
    input  rsp0_ready, rsp1_ready, cond_ifun,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid,
    output rsp_valE, cc, Cnd
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port shared Y86 ALU with one result slot, CC register and Cnd.
// ALU_SHARE_RR_EN: round-robin arbitration (else fixed priority to port 0).
module alu_share_arbiter (
  input logic        clock,
  input logic        reset,
  alu_share_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        own_q, own_d;
  logic [63:0] valE_q, valE_d;
  logic [2:0]  cc_q, cc_d;

  logic        drain, can_grant, grant, sel;
  logic [63:0] a, b, sum, diff, y;
  logic [3:0]  fun;
  logic        set_cc, of;
  logic        zf, sf, ov;

`ifdef ALU_SHARE_RR_EN
  logic last_q, last_d;

  // On contention the port not granted last time wins
  always_comb begin
    sel = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid)
      sel = ~last_q;
  end

  always_comb begin
    last_d = last_q;
    if (grant)
      last_d = sel;
  end

  always_ff @(posedge clock) begin
    if (reset)
      last_q <= 1'b1;
    else
      last_q <= last_d;
  end
`else
  always_comb sel = ~bus.req0_valid;
`endif

  always_comb begin
    drain = (state_q == FULL) &&
            (own_q ? bus.rsp1_ready : bus.rsp0_ready);
    can_grant = (state_q == EMPTY) || drain;
    grant = can_grant && (bus.req0_valid || bus.req1_valid);
  end

  always_comb begin
    a      = sel ? bus.req1_aluA   : bus.req0_aluA;
    b      = sel ? bus.req1_aluB   : bus.req0_aluB;
    fun    = sel ? bus.req1_alufun : bus.req0_alufun;
    set_cc = sel ? bus.req1_set_cc : bus.req0_set_cc;
    sum    = b + a;
    diff   = b - a;
    y      = sum;
    of     = (a[63] == b[63]) && (a[63] != sum[63]);
    case (fun)
      4'd1: begin
        y  = diff;
        of = (a[63] != b[63]) && (b[63] != diff[63]);
      end
      4'd2: begin
        y  = b & a;
        of = 1'b0;
      end
      4'd3: begin
        y  = b ^ a;
        of = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    valE_d  = valE_q;
    cc_d    = cc_q;
    if (grant) begin
      state_d = FULL;
      own_d   = sel;
      valE_d  = y;
      if (set_cc)
        cc_d = {y == 64'd0, y[63], of};
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      own_q   <= 1'b0;
      valE_q  <= 64'd0;
      cc_q    <= 3'b100;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      valE_q  <= valE_d;
      cc_q    <= cc_d;
    end
  end

  always_comb begin
    zf = cc_q[2];
    sf = cc_q[1];
    ov = cc_q[0];
    bus.Cnd = 1'b0;
    case (bus.cond_ifun)
      4'd0: bus.Cnd = 1'b1;
      4'd1: bus.Cnd = (sf ^ ov) | zf;
      4'd2: bus.Cnd = sf ^ ov;
      4'd3: bus.Cnd = zf;
      4'd4: bus.Cnd = ~zf;
      4'd5: bus.Cnd = ~(sf ^ ov);
      4'd6: bus.Cnd = ~(sf ^ ov) & ~zf;
      default: bus.Cnd = 1'b0;
    endcase
  end

  assign bus.req0_ready = grant & ~sel;
  assign bus.req1_ready = grant & sel;
  assign bus.rsp0_valid = (state_q == FULL) & ~own_q;
  assign bus.rsp1_valid = (state_q == FULL) & own_q;
  assign bus.rsp_valE   = valE_q;
  assign bus.cc         = cc_q;

endmodule
